instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage for the veriRISCV core. It owns the program counter and issues word fetches on the instruction bus with at most one request outstanding. It registers each returned instruction together with its PC and hands the pair to the decoder through a valid/ready handshake. Branch redirects from execute flush in-flight work.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: core clock.
- `rst_b` in 1: reset, asynchronous, active-low.
- `ibus_req` out 1: fetch request valid.
- `ibus_addr` out 32: fetch address; always equals `pc`.
- `ibus_ready` in 1: bus accepts the request when `ibus_req && ibus_ready`.
- `ibus_rvalid` in 1: read data valid; the bus returns responses in order, one or more cycles after acceptance.
- `ibus_rdata` in 32: instruction word.
- `if_valid` out 1: the output register holds an instruction.
- `if_instr` out 32: instruction to the decoder.
- `if_pc` out 32: PC of `if_instr`.
- `if_fault` out 1: the held entry is an instruction-address-misaligned fault.
- `id_ready` in 1: the decoder consumes the entry when `if_valid && id_ready`.
- `branch_take` in 1: redirect pulse from execute.
- `branch_target` in 32: redirect PC.

## Operation
**Registers**
- `pc`, `state`, and the output register {`if_valid`, `if_instr`, `if_pc`, `if_fault`}.

**States**
- `REQ`:
  - Drive `ibus_req = !fault_pending && (!if_valid || id_ready)`.
  - On acceptance, move to `WAIT`.
  - If `pc[1:0] != 0`, go to `FAULT` instead of issuing.
- `WAIT`:
  - On `ibus_rvalid`, load the output register with {1, `ibus_rdata`, `pc`, 0}.
  - In the same cycle set `pc <= pc + 4` and move to `REQ`.
- `DROP`:
  - A stale request is in flight.
  - On `ibus_rvalid`, discard the data and move to `REQ`.
- `FAULT`:
  - Load the output register with {1, 32'h0000_0013 (NOP), `pc`, 1} once, when the output register is free.
  - Then hold with no requests until `branch_take`.

**Ignored responses**
- `ibus_rvalid` in `REQ` or `FAULT` is ignored.

**Consume**
- `if_valid && id_ready` clears `if_valid` unless the register is reloaded in the same cycle.
- Load takes priority over clear.

**Redirect (`branch_take`) has highest priority**
- `pc <= branch_target`.
- `if_valid <= 0`; the held entry is discarded even if consumed that cycle.
- From `WAIT`, go to `DROP`, unless `ibus_rvalid` is also asserted; then discard the data and go to `REQ`.
- From `REQ`, if the request is accepted the same cycle, go to `DROP`; otherwise go to `REQ`.
- From `DROP`, stay in `DROP` with the new `pc`. If `ibus_rvalid` is also asserted, go to `REQ`.
- From `FAULT`, go to `REQ`.

**Arithmetic**
- `pc + 4` wraps modulo 2^32 (32'hFFFF_FFFC goes to 0).

## Timing
**Reset values**
- `pc = RESET_PC`, `state = REQ`.
- `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `if_fault = 0`.
- `ibus_req` asserts in the first cycle after `rst_b` deasserts.

**Path types**
- `ibus_req` and `ibus_addr` are decoded combinationally from registers and `id_ready`.
- All other outputs come directly from flops.

**Latencies**
- Acceptance at cycle N with `ibus_rvalid` at N+k gives `if_valid` high at N+k+1.
- The next request can issue at N+k+1.
- Peak throughput with a 1-cycle bus is one instruction per 2 cycles.
- `branch_take` at N with no stale request gives `ibus_addr = branch_target` at N+1.
- `branch_take` at N with a stale request gives the target request after the stale `ibus_rvalid` drains.

**Reset mid-operation**
- Asserting `rst_b` mid-operation returns everything to reset values immediately.
- The bus must be reset by the same `rst_b`.

## Structure
- Shared header (core.vh):
  - `IF_STATE_*` encodings (2 bits).
  - `CORE_NOP` = 32'h0000_0013.
  - Default `RESET_PC`.
- Reuse `DATA_RANGE` for all 32-bit buses.
- No sub-module: the FSM, PC and output register live in one module.

## Test plan
- **Reset and streaming**:
  - Stimulus: `RESET_PC` = 0x100, zero-wait bus returning words 0xA0, 0xA1, …, `id_ready` = 1.
  - Response: `ibus_addr` sequence 0x100, 0x104, 0x108; `if_pc`/`if_instr` pairs (0x100, 0xA0), (0x104, 0xA1), …; `if_fault` = 0.
- **Backpressure**:
  - Stimulus: `id_ready` = 0 for 5 cycles after the first instruction arrives.
  - Response: `if_valid` is held with (0x100, 0xA0); `ibus_req` stays low; the next request (0x104) issues in the cycle `id_ready` rises.
- **Redirect while in `WAIT`**:
  - Stimulus: `branch_take` with target 0x200 while the 0x104 fetch is outstanding.
  - Response: `if_valid` drops next cycle; the 0x104 data is discarded; the next `ibus_addr` is 0x200; the first entry delivered has `if_pc` = 0x200.
- **Same-cycle events**:
  - Stimulus: `branch_take` coincident with `ibus_rvalid`, then coincident with request acceptance.
  - Response: the first case goes straight to `REQ` at the target; the second goes through `DROP` and discards exactly one response.
- **Misaligned target**:
  - Stimulus: `branch_target` = 0x202.
  - Response: no `ibus_req`; one entry with `if_pc` = 0x202, `if_instr` = 0x13, `if_fault` = 1; then idle until the next `branch_take` to 0x300 resumes fetch.
- **Wrap and async reset**:
  - Stimulus: redirect to 0xFFFF_FFFC, then assert `rst_b` low during `WAIT`.
  - Response: the wrap produces the next address 0x0; the reset clears all outputs asynchronously and restarts fetch at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: state encodings,
// the NOP word, the default reset PC and the output entry.
package instruction_fetch_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IF_STATE_REQ   = 2'd0,
    IF_STATE_WAIT  = 2'd1,
    IF_STATE_DROP  = 2'd2,
    IF_STATE_FAULT = 2'd3
  } if_state_e;

  localparam word_t CORE_NOP      = 32'h0000_0013;
  localparam word_t CORE_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    logic  fault;
  } if_entry_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one bus request in flight,
// and registers each instruction with its PC for decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter word_t RESET_PC = CORE_RESET_PC
) (
  input  logic  clk,
  input  logic  rst_b,
  output logic  ibus_req,
  output word_t ibus_addr,
  input  logic  ibus_ready,
  input  logic  ibus_rvalid,
  input  word_t ibus_rdata,
  output logic  if_valid,
  output word_t if_instr,
  output word_t if_pc,
  output logic  if_fault,
  input  logic  id_ready,
  input  logic  branch_take,
  input  word_t branch_target
);

  if_state_e state_q;
  word_t     pc_q;
  if_entry_t out_q;
  logic      fault_sent_q;

  logic misaligned;
  logic accept;
  logic consume;
  logic out_free;

  assign misaligned = pc_q[1:0] != 2'b00;
  assign out_free   = !out_q.valid || id_ready;
  assign consume    = out_q.valid && id_ready;

  assign ibus_req  = (state_q == IF_STATE_REQ)
                   && !misaligned && out_free;
  assign ibus_addr = pc_q;
  assign accept    = ibus_req && ibus_ready;

  assign if_valid = out_q.valid;
  assign if_instr = out_q.instr;
  assign if_pc    = out_q.pc;
  assign if_fault = out_q.fault;

  // FSM, PC and output register; redirect overrides everything
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IF_STATE_REQ;
      pc_q         <= RESET_PC;
      out_q        <= '0;
      fault_sent_q <= 1'b0;
    end else if (branch_take) begin
      pc_q         <= branch_target;
      out_q.valid  <= 1'b0;
      fault_sent_q <= 1'b0;
      unique case (state_q)
        IF_STATE_REQ:
          state_q <= accept ? IF_STATE_DROP
                            : IF_STATE_REQ;
        IF_STATE_WAIT,
        IF_STATE_DROP:
          state_q <= ibus_rvalid ? IF_STATE_REQ
                                 : IF_STATE_DROP;
        IF_STATE_FAULT:
          state_q <= IF_STATE_REQ;
      endcase
    end else begin
      if (consume) out_q.valid <= 1'b0;
      unique case (state_q)
        IF_STATE_REQ: begin
          if (misaligned)  state_q <= IF_STATE_FAULT;
          else if (accept) state_q <= IF_STATE_WAIT;
        end
        IF_STATE_WAIT: begin
          if (ibus_rvalid) begin
            out_q <= '{valid: 1'b1,
                       instr: ibus_rdata,
                       pc:    pc_q,
                       fault: 1'b0};
            pc_q    <= pc_q + 32'd4;
            state_q <= IF_STATE_REQ;
          end
        end
        IF_STATE_DROP: begin
          if (ibus_rvalid) state_q <= IF_STATE_REQ;
        end
        IF_STATE_FAULT: begin
          if (!fault_sent_q && out_free) begin
            out_q <= '{valid: 1'b1,
                       instr: CORE_NOP,
                       pc:    pc_q,
                       fault: 1'b1};
            fault_sent_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: random bus/decoder/redirect
// traffic against a transaction-level model, plus fixed scenarios.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ready = 1'b0;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;
  logic        id_ready = 1'b0;
  logic        branch_take = 1'b0;
  logic [31:0] branch_target = '0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_b(rst_b),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_ready(ibus_ready), .ibus_rvalid(ibus_rvalid),
    .ibus_rdata(ibus_rdata),
    .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_fault(if_fault),
    .id_ready(id_ready), .branch_take(branch_take),
    .branch_target(branch_target)
  );

  int nchk = 0;
  int nerr = 0;

  bit          c_id_ready, c_ibus_ready, c_rand, c_spur;
  int          c_mind, c_maxd, c_br_mode;
  logic [31:0] c_tgt;
  bit          fired;

  bit          b_pending;
  int          b_cnt;
  logic [31:0] b_addr;

  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_v, m_flt, m_busy, m_stale;
  int          m_trap;

  logic [31:0] acc_q[$];
  logic [64:0] con_q[$];

  function automatic logic [31:0] mem(logic [31:0] a);
    return 32'hA0 + ((a - RPC) >> 2);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40)
        $display("FAIL %s @%0t: got %h expected %h",
                 nm, $time, act, exp);
    end
  endtask

  task automatic miss(string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: event never observed", nm);
  endtask

  task automatic chk_acc(string nm, int idx,
                         logic [31:0] exp);
    if (idx >= acc_q.size()) miss(nm);
    else chk(nm, acc_q[idx], exp);
  endtask

  task automatic chk_con(string nm, int idx, bit flt,
                         logic [31:0] pc, logic [31:0] ins);
    if (idx >= con_q.size()) miss(nm);
    else begin
      chk({nm, "_fault"}, 32'(con_q[idx][64]), 32'(flt));
      chk({nm, "_pc"}, con_q[idx][63:32], pc);
      chk({nm, "_instr"}, con_q[idx][31:0], ins);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_v = 0; m_instr = '0; m_ipc = '0;
    m_flt = 0; m_busy = 0; m_stale = 0; m_trap = 0;
    b_pending = 0; b_cnt = 0; b_addr = '0;
  endtask

  task automatic cycle();
    bit resp, acc, m_acc, exp_req, fire_now;
    @(negedge clk);
    resp = b_pending && b_cnt == 0;
    ibus_rvalid = resp ||
      (c_spur && !b_pending && $urandom_range(0, 15) == 0);
    ibus_rdata = resp ? mem(b_addr) : $urandom;
    id_ready = c_rand ? ($urandom_range(0, 3) != 0)
                      : c_id_ready;
    ibus_ready = c_rand ? ($urandom_range(0, 2) != 0)
                        : c_ibus_ready;
    branch_take = 1'b0;
    branch_target = $urandom;
    #1;
    case (c_br_mode)
      1: fire_now = 1;
      2: fire_now = b_pending && !resp;
      3: fire_now = resp;
      4: fire_now = ibus_req && ibus_ready;
      default: fire_now = 0;
    endcase
    if (fire_now) begin
      branch_take = 1'b1;
      branch_target = c_tgt;
      c_br_mode = 0;
      fired = 1;
    end else if (c_rand && $urandom_range(0, 19) == 0) begin
      branch_take = 1'b1;
      branch_target = ($urandom_range(0, 7) == 0)
                    ? $urandom : ($urandom & ~32'h3);
    end
    #1;
    exp_req = !m_busy && m_trap == 0 &&
              m_pc[1:0] == 2'b00 && (!m_v || id_ready);
    chk("ibus_req", 32'(ibus_req), 32'(exp_req));
    chk("ibus_addr", ibus_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_v));
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("if_fault", 32'(if_fault), 32'(m_flt));

    acc = ibus_req && ibus_ready;
    if (acc) acc_q.push_back(ibus_addr);
    if (if_valid && id_ready && !branch_take)
      con_q.push_back({if_fault, if_pc, if_instr});

    m_acc = exp_req && ibus_ready;
    if (branch_take) begin
      if (m_busy) begin
        if (ibus_rvalid) begin m_busy = 0; m_stale = 0; end
        else m_stale = 1;
      end else if (m_acc) begin
        m_busy = 1; m_stale = 1;
      end
      m_pc = branch_target; m_v = 0; m_trap = 0;
    end else begin
      if (m_v && id_ready) m_v = 0;
      if (m_busy) begin
        if (ibus_rvalid) begin
          if (!m_stale) begin
            m_v = 1; m_instr = ibus_rdata;
            m_ipc = m_pc; m_flt = 0; m_pc = m_pc + 4;
          end
          m_busy = 0; m_stale = 0;
        end
      end else if (m_trap == 1) begin
        if (!m_v) begin
          m_v = 1; m_instr = 32'h13;
          m_ipc = m_pc; m_flt = 1; m_trap = 2;
        end
      end else if (m_trap == 0) begin
        if (m_pc[1:0] != 2'b00) m_trap = 1;
        else if (m_acc) begin m_busy = 1; m_stale = 0; end
      end
    end

    if (resp) b_pending = 0;
    else if (b_pending) b_cnt--;
    if (acc) begin
      b_pending = 1;
      b_addr = ibus_addr;
      b_cnt = $urandom_range(c_mind, c_maxd);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic fire(int mode, logic [31:0] tgt,
                      output int ai, output int ci);
    c_br_mode = mode; c_tgt = tgt; fired = 0;
    for (int i = 0; i < 60 && !fired; i++) cycle();
    if (!fired) begin
      miss("branch_fire");
      c_br_mode = 0;
    end
    ai = acc_q.size();
    ci = con_q.size();
  endtask

  initial begin
    int ai, ci;
    c_id_ready = 0; c_ibus_ready = 1; c_rand = 0; c_spur = 0;
    c_mind = 0; c_maxd = 0; c_br_mode = 0; c_tgt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_fault", 32'(if_fault), 32'h0);
    @(posedge clk); #2 rst_b = 1'b1;

    // first fetch, then five stalled cycles with data held
    run(8);
    chk("stall_acc_count", 32'(acc_q.size()), 32'd1);
    c_id_ready = 1;
    cycle();
    chk_acc("release_acc", 1, 32'h104);
    run(10);
    chk_acc("stream_a0", 0, 32'h100);
    chk_acc("stream_a2", 2, 32'h108);
    chk_con("stream_e0", 0, 0, 32'h100, 32'hA0);
    chk_con("stream_e1", 1, 0, 32'h104, 32'hA1);

    // redirect while a fetch is outstanding
    c_mind = 1; c_maxd = 1;
    fire(2, 32'h200, ai, ci);
    run(12);
    chk_acc("wait_redir_acc", ai, 32'h200);
    chk_con("wait_redir_e", ci, 0, 32'h200, 32'hE0);

    // redirect with rvalid, then with acceptance
    c_mind = 0; c_maxd = 0;
    fire(3, 32'h400, ai, ci);
    run(8);
    chk_acc("rv_redir_acc", ai, 32'h400);
    fire(4, 32'h500, ai, ci);
    run(8);
    chk_acc("acc_redir_acc", ai, 32'h500);
    chk_con("acc_redir_e", ci, 0, 32'h500, 32'h1A0);

    // misaligned target parks until the next redirect
    fire(1, 32'h202, ai, ci);
    run(10);
    chk("mis_no_req", 32'(acc_q.size()), 32'(ai));
    chk("mis_one_entry", 32'(con_q.size()), 32'(ci + 1));
    chk_con("mis_e", ci, 1, 32'h202, 32'h13);
    fire(1, 32'h300, ai, ci);
    run(6);
    chk_acc("mis_resume", ai, 32'h300);

    // PC wrap
    fire(1, 32'hFFFF_FFFC, ai, ci);
    run(6);
    chk_acc("wrap_a0", ai, 32'hFFFF_FFFC);
    chk_acc("wrap_a1", ai + 1, 32'h0);

    // asynchronous reset while waiting on the bus
    c_mind = 2; c_maxd = 2;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        cycle();
        got = b_pending && b_cnt > 0;
      end
      if (!got) miss("reset_wait_state");
    end
    @(posedge clk); #2 rst_b = 1'b0;
    #1;
    chk("arst_if_valid", 32'(if_valid), 32'h0);
    chk("arst_if_instr", if_instr, 32'h0);
    chk("arst_if_pc", if_pc, 32'h0);
    chk("arst_if_fault", 32'(if_fault), 32'h0);
    chk("arst_ibus_addr", ibus_addr, RPC);
    branch_take = 1'b0; ibus_rvalid = 1'b0;
    model_reset();
    ai = acc_q.size();
    @(posedge clk); #2 rst_b = 1'b1;
    c_mind = 0; c_maxd = 0;
    run(4);
    chk_acc("arst_restart", ai, RPC);

    // random traffic
    c_rand = 1; c_spur = 1; c_mind = 0; c_maxd = 3;
    run(3000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
